ahb_sram_slave: RTL and testbench

AHB slave that services the 0x00000000–0x0FFFFFFF window selected by the address decoder's HSELx1 output, backed by an on-chip word-organised memory. Sits directly downstream of the decoder: it qualifies transfers with its HSELx input, the bus HREADY and HTRANS; inserts a configurable number of wait states; and returns a two-cycle ERROR response for illegal transfers. Its HREADYOUT/HRESP/HRDATA feed the slave-to-master response multiplexor.

---
 rtl/ahb_sram_slave_if.sv | 25 ++
 rtl/ahb_sram_slave.sv | 143 ++++++++++++++
 tb/tb_ahb_sram_slave.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/ahb_sram_slave_if.sv
// AHB bus signals between the decoder/response mux and the SRAM slave.
// Each bus signal is declared once; the modports only set the direction seen by each side.
interface ahb_sram_slave_if;
    logic        HSELx;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic [1:0]  HRESP;
    logic [31:0] HRDATA;

    modport slave (
        input  HSELx, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );

    modport master (
        output HSELx, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB SRAM slave: word-organised memory, WAIT_STATES wait cycles per transfer.
// Define SRAM_ERROR_RESP_EN to enable illegal-transfer checks and the two-cycle ERROR response.
module ahb_sram_slave #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic             HCLK,
    input  logic             HRESET,
    ahb_sram_slave_if.slave  bus
);
    localparam int         DEPTH      = 1 << ADDR_WIDTH;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

`ifdef SRAM_ERROR_RESP_EN
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT} state_t;
`endif

    state_t                state, state_next;
    logic [1:0]            wait_cnt, wait_cnt_next;
    logic                  pend_valid, pend_write;
    logic [1:0]            pend_size;
    logic [ADDR_WIDTH+1:0] pend_addr;
    logic [31:0]           mem [DEPTH];

    logic                  accept, illegal, take, complete, do_write, ready_out;
    logic [1:0]            resp_out, size_eff;
    logic [3:0]            byte_en;
    logic [31:0]           rd_word;
    logic                  unused_bits;

    assign accept   = bus.HSELx & bus.HREADY & bus.HTRANS[1];
    assign size_eff = (bus.HSIZE == 3'b000) ? 2'd0 :
                      (bus.HSIZE == 3'b001) ? 2'd1 : 2'd2;

`ifdef SRAM_ERROR_RESP_EN
    assign illegal = (bus.HSIZE > 3'b010)
                   || ((bus.HSIZE == 3'b001) && bus.HADDR[0])
                   || ((bus.HSIZE == 3'b010) && (bus.HADDR[1:0] != 2'b00))
                   || ((bus.HADDR[27:0] >> (ADDR_WIDTH + 2)) != 28'd0);
`else
    assign illegal = 1'b0;
`endif

    assign take     = ready_out & accept & ~illegal;
    assign complete = ready_out & pend_valid;
    assign do_write = complete & pend_write & ~HRESET;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state      <= ST_IDLE;
            wait_cnt   <= 2'd0;
            pend_valid <= 1'b0;
            pend_write <= 1'b0;
            pend_size  <= 2'd0;
            pend_addr  <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (take) begin
                pend_valid <= 1'b1;
                pend_write <= bus.HWRITE;
                pend_size  <= size_eff;
                pend_addr  <= bus.HADDR[ADDR_WIDTH+1:0];
            end else if (complete) begin
                pend_valid <= 1'b0;
                pend_write <= 1'b0;
            end
        end
    end

    // A new address phase is only considered in cycles where this slave reports ready.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        ready_out     = 1'b1;
        resp_out      = RESP_OKAY;
        case (state)
            ST_WAIT: begin
                ready_out = 1'b0;
                if (wait_cnt == 2'd1) begin
                    state_next    = ST_IDLE;
                    wait_cnt_next = 2'd0;
                end else begin
                    wait_cnt_next = wait_cnt - 2'd1;
                end
            end
`ifdef SRAM_ERROR_RESP_EN
            ST_ERR1: begin
                ready_out  = 1'b0;
                resp_out   = RESP_ERROR;
                state_next = ST_ERR2;
            end
            ST_ERR2: begin
                resp_out   = RESP_ERROR;
                state_next = ST_IDLE;
            end
`endif
            default: ;
        endcase
        if (ready_out && accept) begin
            if (illegal) begin
`ifdef SRAM_ERROR_RESP_EN
                state_next = ST_ERR1;
`endif
            end else if (WAIT_STATES > 0) begin
                state_next    = ST_WAIT;
                wait_cnt_next = 2'(WAIT_STATES);
            end else begin
                state_next = ST_IDLE;
            end
        end
    end

    always_comb begin
        byte_en = 4'b1111;
        case (pend_size)
            2'd0:    byte_en = 4'b0001 << pend_addr[1:0];
            2'd1:    byte_en = pend_addr[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[pend_addr[ADDR_WIDTH+1:2]][8*b +: 8] <= bus.HWDATA[8*b +: 8];
                end
            end
        end
    end

    // Asynchronous read lets a write committed at the previous edge be seen immediately.
    assign rd_word       = mem[pend_addr[ADDR_WIDTH+1:2]];
    assign bus.HRDATA    = (complete && !pend_write) ? rd_word : 32'd0;
    assign bus.HREADYOUT = ready_out;
    assign bus.HRESP     = resp_out;

    assign unused_bits = ^{bus.HBURST, bus.HTRANS[0], bus.HADDR, bus.HSIZE};
endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed testbench for ahb_sram_slave: one instance with zero and one with two wait states.
// Error-response expectations follow whether SRAM_ERROR_RESP_EN is defined.
module tb_ahb_sram_slave;
    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [2:0] SZ_BYTE  = 3'b000;
    localparam logic [2:0] SZ_HALF  = 3'b001;
    localparam logic [2:0] SZ_WORD  = 3'b010;

    logic HCLK;
    logic HRESET;
    logic hold_off;
    int   checks;
    int   errors;

    ahb_sram_slave_if bus0();
    ahb_sram_slave_if bus2();

    assign bus0.HREADY = bus0.HREADYOUT & ~hold_off;
    assign bus2.HREADY = bus2.HREADYOUT;

    ahb_sram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut0 (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus0.slave)
    );

    ahb_sram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(2)) dut2 (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus2.slave)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drives one bus cycle just after the rising edge, then leaves time for outputs to settle.
    task automatic applyStimulus(input int port, input logic sel, input logic [1:0] trans,
                                 input logic write, input logic [2:0] size,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        @(posedge HCLK);
        #1;
        if (port == 0) begin
            bus0.HSELx  = sel;
            bus0.HTRANS = trans;
            bus0.HWRITE = write;
            bus0.HSIZE  = size;
            bus0.HADDR  = addr;
            bus0.HWDATA = wdata;
        end else begin
            bus2.HSELx  = sel;
            bus2.HTRANS = trans;
            bus2.HWRITE = write;
            bus2.HSIZE  = size;
            bus2.HADDR  = addr;
            bus2.HWDATA = wdata;
        end
        #1;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        hold_off = 1'b0;
        HRESET   = 1'b1;
        bus0.HSELx = 1'b0; bus0.HTRANS = T_IDLE; bus0.HWRITE = 1'b0; bus0.HSIZE = SZ_WORD;
        bus0.HADDR = 32'd0; bus0.HWDATA = 32'd0; bus0.HBURST = 3'b000;
        bus2.HSELx = 1'b0; bus2.HTRANS = T_IDLE; bus2.HWRITE = 1'b0; bus2.HSIZE = SZ_WORD;
        bus2.HADDR = 32'd0; bus2.HWDATA = 32'd0; bus2.HBURST = 3'b000;
        repeat (2) @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        #1;
        $display("[TB] reset values");
        checkOutput("rst ready0", 32'(bus0.HREADYOUT), 32'd1);
        checkOutput("rst resp0",  32'(bus0.HRESP),     32'd0);
        checkOutput("rst rdata0", bus0.HRDATA,         32'd0);
        checkOutput("rst ready2", 32'(bus2.HREADYOUT), 32'd1);
        checkOutput("rst rdata2", bus2.HRDATA,         32'd0);

        $display("[TB] zero-wait write then read");
        applyStimulus(0, 1'b1, T_NONSEQ, 1'b1, SZ_WORD, 32'h0000_0000, 32'd0);
        applyStimulus(0, 1'b1, T_NONSEQ, 1'b1, SZ_WORD, 32'h0000_0010, 32'hCAFE_F00D);
        checkOutput("w0 ready", 32'(bus0.HREADYOUT), 32'd1);
        applyStimulus(0, 1'b1, T_NONSEQ, 1'b0, SZ_WORD, 32'h0000_0010, 32'hDEAD_BEEF);
        checkOutput("w10 ready", 32'(bus0.HREADYOUT), 32'd1);
        checkOutput("w10 rdata", bus0.HRDATA,         32'd0);
        applyStimulus(0, 1'b1, T_IDLE,   1'b0, SZ_WORD, 32'h0000_0000, 32'd0);
        checkOutput("r10 ready", 32'(bus0.HREADYOUT), 32'd1);
        checkOutput("r10 resp",  32'(bus0.HRESP),     32'd0);
        checkOutput("r10 rdata", bus0.HRDATA,         32'hDEAD_BEEF);

        $display("[TB] byte and halfword lanes");
        applyStimulus(0, 1'b1, T_NONSEQ, 1'b1, SZ_WORD, 32'h0000_0010, 32'd0);
        applyStimulus(0, 1'b1, T_NONSEQ, 1'b1, SZ_BYTE, 32'h0000_0013, 32'h1122_3344);
        applyStimulus(0, 1'b1, T_NONSEQ, 1'b0, SZ_WORD, 32'h0000_0010, 32'hAA55_6677);
        applyStimulus(0, 1'b1, T_NONSEQ, 1'b1, SZ_HALF, 32'h0000_0010, 32'd0);
        checkOutput("byte rd", bus0.HRDATA, 32'hAA22_3344);
        applyStimulus(0, 1'b1, T_NONSEQ, 1'b1, SZ_HALF, 32'h0000_0012, 32'h9999_BEEF);
        checkOutput("half wr rdata", bus0.HRDATA, 32'd0);
        applyStimulus(0, 1'b1, T_NONSEQ, 1'b0, SZ_WORD, 32'h0000_0010, 32'h5A5A_1234);
        applyStimulus(0, 1'b1, T_IDLE,   1'b0, SZ_WORD, 32'h0000_0000, 32'd0);
        checkOutput("half rd", bus0.HRDATA, 32'h5A5A_BEEF);

        $display("[TB] unselected and stalled bus");
        applyStimulus(0, 1'b0, T_NONSEQ, 1'b0, SZ_WORD, 32'h0000_0010, 32'd0);
        applyStimulus(0, 1'b1, T_IDLE,   1'b0, SZ_WORD, 32'h0000_0000, 32'd0);
        checkOutput("unsel rdata", bus0.HRDATA, 32'd0);
        hold_off = 1'b1;
        applyStimulus(0, 1'b1, T_NONSEQ, 1'b0, SZ_WORD, 32'h0000_0010, 32'd0);
        applyStimulus(0, 1'b1, T_IDLE,   1'b0, SZ_WORD, 32'h0000_0000, 32'd0);
        checkOutput("stall ready", 32'(bus0.HREADYOUT), 32'd1);
        checkOutput("stall rdata", bus0.HRDATA,         32'd0);
        hold_off = 1'b0;

`ifdef SRAM_ERROR_RESP_EN
        $display("[TB] error responses");
        applyStimulus(0, 1'b1, T_NONSEQ, 1'b0, SZ_WORD, 32'h0000_0002, 32'd0);
        applyStimulus(0, 1'b1, T_NONSEQ, 1'b0, SZ_WORD, 32'h0000_0000, 32'd0);
        checkOutput("err1 ready", 32'(bus0.HREADYOUT), 32'd0);
        checkOutput("err1 resp",  32'(bus0.HRESP),     32'd1);
        checkOutput("err1 rdata", bus0.HRDATA,         32'd0);
        applyStimulus(0, 1'b1, T_NONSEQ, 1'b0, SZ_WORD, 32'h0000_0000, 32'd0);
        checkOutput("err2 ready", 32'(bus0.HREADYOUT), 32'd1);
        checkOutput("err2 resp",  32'(bus0.HRESP),     32'd1);
        applyStimulus(0, 1'b1, T_IDLE,   1'b0, SZ_WORD, 32'h0000_0000, 32'd0);
        checkOutput("after err resp",  32'(bus0.HRESP), 32'd0);
        checkOutput("after err rdata", bus0.HRDATA,     32'hCAFE_F00D);

        applyStimulus(0, 1'b1, T_NONSEQ, 1'b1, SZ_WORD, 32'h0000_1000, 32'd0);
        applyStimulus(0, 1'b1, T_IDLE,   1'b0, SZ_WORD, 32'h0000_0000, 32'h1234_5678);
        checkOutput("oob err1 ready", 32'(bus0.HREADYOUT), 32'd0);
        checkOutput("oob err1 resp",  32'(bus0.HRESP),     32'd1);
        applyStimulus(0, 1'b1, T_IDLE,   1'b0, SZ_WORD, 32'h0000_0000, 32'h1234_5678);
        checkOutput("oob err2 resp",  32'(bus0.HRESP),     32'd1);
        applyStimulus(0, 1'b1, T_NONSEQ, 1'b0, SZ_WORD, 32'h0000_0000, 32'd0);
        applyStimulus(0, 1'b1, T_IDLE,   1'b0, SZ_WORD, 32'h0000_0000, 32'd0);
        checkOutput("oob no write", bus0.HRDATA, 32'hCAFE_F00D);

        applyStimulus(0, 1'b1, T_NONSEQ, 1'b0, SZ_HALF, 32'h0000_0001, 32'd0);
        applyStimulus(0, 1'b1, T_IDLE,   1'b0, SZ_WORD, 32'h0000_0000, 32'd0);
        checkOutput("half odd resp",  32'(bus0.HRESP),     32'd1);
        checkOutput("half odd ready", 32'(bus0.HREADYOUT), 32'd0);
        applyStimulus(0, 1'b1, T_IDLE,   1'b0, SZ_WORD, 32'h0000_0000, 32'd0);
`else
        $display("[TB] unchecked transfers");
        applyStimulus(0, 1'b1, T_NONSEQ, 1'b0, SZ_WORD, 32'h0000_0002, 32'd0);
        applyStimulus(0, 1'b1, T_IDLE,   1'b0, SZ_WORD, 32'h0000_0000, 32'd0);
        checkOutput("unalign ready", 32'(bus0.HREADYOUT), 32'd1);
        checkOutput("unalign resp",  32'(bus0.HRESP),     32'd0);
        checkOutput("unalign rdata", bus0.HRDATA,         32'hCAFE_F00D);
        applyStimulus(0, 1'b1, T_NONSEQ, 1'b1, SZ_WORD, 32'h0000_1000, 32'd0);
        applyStimulus(0, 1'b1, T_NONSEQ, 1'b0, SZ_WORD, 32'h0000_0000, 32'h1234_5678);
        checkOutput("wrap resp", 32'(bus0.HRESP), 32'd0);
        applyStimulus(0, 1'b1, T_IDLE,   1'b0, SZ_WORD, 32'h0000_0000, 32'd0);
        checkOutput("wrap rdata", bus0.HRDATA, 32'h1234_5678);
`endif

        $display("[TB] two wait states");
        applyStimulus(2, 1'b1, T_NONSEQ, 1'b1, SZ_WORD, 32'h0000_0040, 32'd0);
        applyStimulus(2, 1'b1, T_IDLE,   1'b0, SZ_WORD, 32'h0000_0000, 32'h0BAD_CAFE);
        checkOutput("ws wr w1", 32'(bus2.HREADYOUT), 32'd0);
        applyStimulus(2, 1'b1, T_IDLE,   1'b0, SZ_WORD, 32'h0000_0000, 32'h0BAD_CAFE);
        checkOutput("ws wr w2", 32'(bus2.HREADYOUT), 32'd0);
        applyStimulus(2, 1'b1, T_IDLE,   1'b0, SZ_WORD, 32'h0000_0000, 32'h0BAD_CAFE);
        checkOutput("ws wr done", 32'(bus2.HREADYOUT), 32'd1);
        applyStimulus(2, 1'b1, T_NONSEQ, 1'b0, SZ_WORD, 32'h0000_0040, 32'd0);
        applyStimulus(2, 1'b1, T_NONSEQ, 1'b0, SZ_WORD, 32'h0000_0044, 32'd0);
        checkOutput("ws rd w1 ready", 32'(bus2.HREADYOUT), 32'd0);
        checkOutput("ws rd w1 rdata", bus2.HRDATA,         32'd0);
        applyStimulus(2, 1'b1, T_NONSEQ, 1'b0, SZ_WORD, 32'h0000_0044, 32'd0);
        checkOutput("ws rd w2 ready", 32'(bus2.HREADYOUT), 32'd0);
        applyStimulus(2, 1'b1, T_NONSEQ, 1'b0, SZ_WORD, 32'h0000_0044, 32'd0);
        checkOutput("ws rd ready", 32'(bus2.HREADYOUT), 32'd1);
        checkOutput("ws rd rdata", bus2.HRDATA,         32'h0BAD_CAFE);
        applyStimulus(2, 1'b1, T_IDLE,   1'b0, SZ_WORD, 32'h0000_0000, 32'd0);
        checkOutput("ws next accepted", 32'(bus2.HREADYOUT), 32'd0);
        applyStimulus(2, 1'b1, T_IDLE,   1'b0, SZ_WORD, 32'h0000_0000, 32'd0);
        applyStimulus(2, 1'b1, T_IDLE,   1'b0, SZ_WORD, 32'h0000_0000, 32'd0);
        checkOutput("ws next done", 32'(bus2.HREADYOUT), 32'd1);

        $display("[TB] reset during a waited write");
        applyStimulus(2, 1'b1, T_NONSEQ, 1'b1, SZ_WORD, 32'h0000_0048, 32'd0);
        applyStimulus(2, 1'b1, T_IDLE,   1'b0, SZ_WORD, 32'h0000_0000, 32'h1111_1111);
        applyStimulus(2, 1'b1, T_IDLE,   1'b0, SZ_WORD, 32'h0000_0000, 32'h1111_1111);
        applyStimulus(2, 1'b1, T_IDLE,   1'b0, SZ_WORD, 32'h0000_0000, 32'h1111_1111);
        applyStimulus(2, 1'b1, T_NONSEQ, 1'b1, SZ_WORD, 32'h0000_0048, 32'd0);
        applyStimulus(2, 1'b1, T_IDLE,   1'b0, SZ_WORD, 32'h0000_0000, 32'h2222_2222);
        HRESET = 1'b1;
        checkOutput("rst wait ready", 32'(bus2.HREADYOUT), 32'd0);
        applyStimulus(2, 1'b1, T_IDLE,   1'b0, SZ_WORD, 32'h0000_0000, 32'h2222_2222);
        checkOutput("rst mid ready", 32'(bus2.HREADYOUT), 32'd1);
        checkOutput("rst mid resp",  32'(bus2.HRESP),     32'd0);
        checkOutput("rst mid rdata", bus2.HRDATA,         32'd0);
        HRESET = 1'b0;
        applyStimulus(2, 1'b1, T_NONSEQ, 1'b0, SZ_WORD, 32'h0000_0048, 32'd0);
        applyStimulus(2, 1'b1, T_IDLE,   1'b0, SZ_WORD, 32'h0000_0000, 32'd0);
        applyStimulus(2, 1'b1, T_IDLE,   1'b0, SZ_WORD, 32'h0000_0000, 32'd0);
        applyStimulus(2, 1'b1, T_IDLE,   1'b0, SZ_WORD, 32'h0000_0000, 32'd0);
        checkOutput("rst word kept", bus2.HRDATA, 32'h1111_1111);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
